sar_search: RTL and testbench
=============================

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-005 cmp_valid  input  1  comparator result valid for the current trial.
REQ-006 cmp_L  input  1  trial < target.
REQ-007 cmp_E  input  1  trial == target.
REQ-008 cmp_G  input  1  trial > target.
REQ-009 trial  output  8  value presented as the A operand to the external 8-bit L/E/G comparator.
REQ-010 trial_valid  output  1  trial is stable and a comparison is requested.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when result, exact and err are valid.
REQ-013 result  output  8  final search value, held until the next done.
REQ-014 exact  output  1  an equality (cmp_E) was observed for result.
REQ-015 err  output  1  comparator response was not one-hot.

Function
REQ-016 States SHALL be IDLE, TEST, VERIFY and DONE, held in a registered state machine.
REQ-017 In IDLE with start=1, the block SHALL load trial=8'h80 and bit index=7, then enter TEST on the next edge.
REQ-018 start SHALL be ignored in TEST, VERIFY and DONE.
REQ-019 trial_valid SHALL be 1 only in TEST and VERIFY; trial SHALL NOT change while trial_valid=1 and cmp_valid=0 (wait states of any length allowed).
REQ-020 In TEST with cmp_valid=1, the block SHALL resolve each response as follows:
- {L,E,G} not one-hot -> err=1, exact=0, result=trial, go to DONE.
- E -> result=trial, exact=1, go to DONE (early termination).
- L -> keep the current bit.
- G -> clear the current bit.
REQ-021 After an L/G resolution with index>0, the block SHALL set bit index-1 in trial, decrement the index and stay in TEST.
REQ-022 After an L/G resolution with index==0, the block SHALL enter VERIFY with the updated trial.
REQ-023 In VERIFY with cmp_valid=1, the block SHALL set result=trial, exact=cmp_E and err=(response not one-hot), then go to DONE.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-025 Latency SHALL be at most 9 comparator transactions, plus 1 cycle for DONE and 1 cycle for start in IDLE.
REQ-026 cmp_valid outside TEST/VERIFY SHALL be ignored.
REQ-027 result, exact and err SHALL change only on the edge entering DONE.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE with trial=8'h00, trial_valid=0, busy=0, done=0, result=8'h00, exact=0 and err=0.
REQ-029 Reset asserted mid-search SHALL abort the search with no done pulse; the first start after release SHALL begin a fresh search from 8'h80.

Verification
REQ-030 Target 0x80, zero-wait comparator model: start -> one compare, E -> done 2 cycles after TEST entry with result=0x80, exact=1, err=0.
REQ-031 Target 0xFF: trials 80,C0,E0,F0,F8,FC,FE,FF; E on the 8th compare -> result=0xFF, exact=1; VERIFY is never entered.
REQ-032 Target 0x00: eight G responses -> VERIFY with trial=0x00, E -> result=0x00, exact=1; 9 compares total.
REQ-033 Target 0x5A with random 0-3 cycle cmp_valid delays: trial is held stable during waits -> result=0x5A, exact=1; start pulses during busy are ignored.
REQ-034 Comparator drives L=1 and G=1 on the 3rd compare -> err=1, exact=0, result=0xE0 (the 3rd trial), with a done pulse.
REQ-035 rst asserted during the 4th compare -> outputs take their reset values immediately, no done; a following start with target 0x33 -> result=0x33, exact=1.

Source files
------------

// File: rtl/sar_search_if.sv
// Handshake bundle between the SAR search engine, its requester and the
// external L/E/G comparator. The slave side is the search engine itself.
interface sar_search_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              cmp_valid;
    logic              cmp_L;
    logic              cmp_E;
    logic              cmp_G;
    logic [DATA_W-1:0] trial;
    logic              trial_valid;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              exact;
    logic              err;

    modport master (
        output start, cmp_valid, cmp_L, cmp_E, cmp_G,
        input  trial, trial_valid, busy, done, result, exact, err
    );

    modport slave (
        input  start, cmp_valid, cmp_L, cmp_E, cmp_G,
        output trial, trial_valid, busy, done, result, exact, err
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search driving an external L/E/G comparator.
// Walks the trial value from the MSB down, stops early on equality and
// runs one extra verify compare once every bit has been decided.
module sar_search #(
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    sar_search_if.slave    bus
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] TRIAL_INIT = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        VERIFY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] trial_q, trial_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              exact_q, exact_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] decided_trial;
    logic              resp_ok;

    // A well-formed comparator answer has exactly one of L/E/G set.
    function automatic logic one_hot3(input logic l, input logic e, input logic g);
        return (l & ~e & ~g) | (~l & e & ~g) | (~l & ~e & g);
    endfunction

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            idx_q    <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            exact_q  <= exact_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: resolve each comparator answer into the next trial or a result.
    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        idx_d    = idx_q;
        result_d = result_q;
        exact_d  = exact_q;
        err_d    = err_q;

        resp_ok = one_hot3(bus.cmp_L, bus.cmp_E, bus.cmp_G);

        // G means the trial overshot, so the bit under test is dropped; L keeps it.
        decided_trial = trial_q;
        if (bus.cmp_G) begin
            decided_trial[idx_q] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    trial_d = TRIAL_INIT;
                    idx_d   = IDX_W'(DATA_W - 1);
                    state_d = TEST;
                end
            end
            TEST: begin
                if (bus.cmp_valid) begin
                    if (!resp_ok) begin
                        result_d = trial_q;
                        exact_d  = 1'b0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (bus.cmp_E) begin
                        result_d = trial_q;
                        exact_d  = 1'b1;
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end else if (idx_q != '0) begin
                        trial_d                       = decided_trial;
                        trial_d[idx_q - IDX_W'(1)]    = 1'b1;
                        idx_d                         = idx_q - IDX_W'(1);
                    end else begin
                        // All bits decided without a hit; one last compare confirms it.
                        trial_d = decided_trial;
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (bus.cmp_valid) begin
                    result_d = trial_q;
                    exact_d  = bus.cmp_E;
                    err_d    = !resp_ok;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.trial       = trial_q;
    assign bus.trial_valid = (state_q == TEST) || (state_q == VERIFY);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.exact       = exact_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: random targets, random comparator wait states and
// injected malformed responses, checked against a closed-form search model.
module tb_sar_search;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sar_search_if #(.DATA_W(8)) bus();

    sar_search #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compares needed to hit target t: the hit comes on the trial whose
    // lowest set bit is t's lowest set bit; zero needs eight misses plus verify.
    function automatic int ref_compares(input logic [7:0] t);
        for (int b = 0; b < 8; b++) begin
            if (t[b]) return 8 - b;
        end
        return 9;
    endfunction

    // k-th trial (0-based) while searching for t: t's bits above the bit
    // under test, that bit set, lower bits clear. The verify trial is t itself.
    function automatic logic [7:0] ref_trial(input logic [7:0] t, input int k);
        int b;
        int v;
        if (k >= 8) return t;
        b = 7 - k;
        v = int'(t);
        return 8'(((v >> (b + 1)) << (b + 1)) | (1 << b));
    endfunction

    function automatic logic [2:0] ref_leg(input logic [7:0] tr, input logic [7:0] tgt);
        return {tr < tgt, tr == tgt, tr > tgt};
    endfunction

    task automatic drive_resp(input logic [2:0] leg);
        bus.cmp_L     = leg[2];
        bus.cmp_E     = leg[1];
        bus.cmp_G     = leg[0];
        bus.cmp_valid = 1'b1;
        @(negedge clk);
        bus.cmp_valid = 1'b0;
        bus.cmp_L     = 1'b0;
        bus.cmp_E     = 1'b0;
        bus.cmp_G     = 1'b0;
    endtask

    // One full search. fault_at (1-based, 0 = none) replaces that compare's
    // answer with fpat ({L,E,G}); spam pulses start while waiting.
    task automatic run_search(input logic [7:0] tgt, input int maxd, input int fault_at,
                              input logic [2:0] fpat, input bit spam);
        int         n_nat;
        int         n_exp;
        logic [7:0] res_exp;
        logic       ex_exp;
        logic       er_exp;
        int         k;
        int         d;
        logic       got_done;
        logic       stable;
        logic [7:0] cur;
        logic [2:0] leg;

        n_nat = ref_compares(tgt);
        if (fault_at > 0 && fault_at <= n_nat) begin
            n_exp   = fault_at;
            res_exp = ref_trial(tgt, fault_at - 1);
            er_exp  = 1'b1;
            ex_exp  = (fault_at == 9) ? fpat[1] : 1'b0;
        end else begin
            n_exp   = n_nat;
            res_exp = tgt;
            er_exp  = 1'b0;
            ex_exp  = 1'b1;
        end

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        k        = 0;
        got_done = 1'b0;
        stable   = 1'b1;
        while (!got_done && k < 12) begin
            chk("trial_valid", 32'(bus.trial_valid), 1);
            if (k > 8 || !bus.trial_valid) break;
            chk($sformatf("trial_t%0h_k%0d", tgt, k), 32'(bus.trial), 32'(ref_trial(tgt, k)));
            cur = bus.trial;
            d   = $urandom_range(0, maxd);
            repeat (d) begin
                bus.start = spam & 1'($urandom_range(0, 1));
                @(negedge clk);
                if (bus.trial !== cur || bus.trial_valid !== 1'b1) stable = 1'b0;
            end
            bus.start = 1'b0;
            leg = (k + 1 == fault_at) ? fpat : ref_leg(cur, tgt);
            drive_resp(leg);
            k++;
            got_done = bus.done;
        end

        chk("stable", 32'(stable), 1);
        chk($sformatf("compares_t%0h", tgt), 32'(k), 32'(n_exp));
        chk("done", 32'(got_done), 1);
        chk("result", 32'(bus.result), 32'(res_exp));
        chk("exact", 32'(bus.exact), 32'(ex_exp));
        chk("err", 32'(bus.err), 32'(er_exp));
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        logic [7:0] prev_res;
        logic       done_seen;
        logic [2:0] pat;
        int         fa;

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.cmp_valid = 1'b0;
        bus.cmp_L     = 1'b0;
        bus.cmp_E     = 1'b0;
        bus.cmp_G     = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_trial", 32'(bus.trial), 0);
        chk("rst_trial_valid", 32'(bus.trial_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_exact", 32'(bus.exact), 0);
        chk("rst_err", 32'(bus.err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_search(8'h80, 0, 0, 3'b000, 1'b0);
        run_search(8'hFF, 0, 0, 3'b000, 1'b0);
        run_search(8'h00, 0, 0, 3'b000, 1'b0);
        run_search(8'h5A, 3, 0, 3'b000, 1'b1);

        // Comparator chatter while idle must not start anything.
        prev_res = bus.result;
        bus.cmp_E     = 1'b1;
        bus.cmp_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.cmp_valid = 1'b0;
        bus.cmp_E     = 1'b0;
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_trial_valid", 32'(bus.trial_valid), 0);
        chk("idle_result", 32'(bus.result), 32'(prev_res));

        run_search(8'hFF, 1, 3, 3'b101, 1'b0);
        run_search(8'h00, 0, 9, 3'b011, 1'b0);
        run_search(8'h01, 2, 9, 3'b000, 1'b1);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 4))
                0:       pat = 3'b000;
                1:       pat = 3'b011;
                2:       pat = 3'b101;
                3:       pat = 3'b110;
                default: pat = 3'b111;
            endcase
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
            run_search(8'($urandom_range(0, 255)), 3, fa, pat, 1'($urandom_range(0, 1)));
        end

        // Abort a search during its 4th compare.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) drive_resp(ref_leg(bus.trial, 8'h33));
        chk("abort_tv", 32'(bus.trial_valid), 1);
        chk("abort_trial", 32'(bus.trial), 32'(ref_trial(8'h33, 3)));
        #2 rst = 1'b1;
        #1;
        chk("abort_trial_rst", 32'(bus.trial), 0);
        chk("abort_tv_rst", 32'(bus.trial_valid), 0);
        chk("abort_busy_rst", 32'(bus.busy), 0);
        chk("abort_done_rst", 32'(bus.done), 0);
        chk("abort_result_rst", 32'(bus.result), 0);
        chk("abort_exact_rst", 32'(bus.exact), 0);
        chk("abort_err_rst", 32'(bus.err), 0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        chk("abort_no_done", 32'(done_seen), 0);
        run_search(8'h33, 1, 0, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
